// File: rtl/rbz_spi_regs.sv
// SPI-slave register bank: synchronised SPI pins, address+data frame decode,
// shadow registers committed on a frame-boundary strobe (or written straight through).
//
// state  | meaning
// IDLE   | waiting for synced ss_n low
// SHIFT  | collecting frame bits on sclk rising edges
// DONE   | one cycle: frame complete, write shadow/live register
// IGNORE | frame done, discard further sclk until ss_n high
module rbz_spi_regs #(
   parameter int ADDR_W      = 3,
   parameter int REG_W       = 16,
   parameter int SYNC_STAGES = 2,
   parameter int IMMEDIATE   = 0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             i_sclk,
   input  logic                             i_mosi,
   input  logic                             i_ss_n,
   input  logic                             i_commit,
   output logic [(2**ADDR_W)*REG_W-1:0]     o_regs,
   output logic [(2**ADDR_W)-1:0]           o_pending,
   output logic                             o_busy,
   output logic                             o_frame_err
);

   localparam int NREG  = 2**ADDR_W;
   localparam int F     = ADDR_W + REG_W;
   localparam int CNT_W = $clog2(F + 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_DONE   = 2'd2,
      ST_IGNORE = 2'd3
   } state_t;

   logic [SYNC_STAGES-1:0] sclk_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic                   sclk_prev_q;
   logic                   sclk_s;
   logic                   mosi_s;
   logic                   ss_s;
   logic                   sclk_rise;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [F-1:0]           shift_q, shift_d;
   logic                   frame_err_q, frame_err_d;

   logic                   wr_en;
   logic [ADDR_W-1:0]      wr_addr;
   logic [REG_W-1:0]       wr_data;

   logic [REG_W-1:0]       live_q [NREG];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         ss_sync_q   <= '1;
         sclk_prev_q <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_sclk};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], i_ss_n};
         sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         shift_q     <= shift_d;
         frame_err_q <= frame_err_d;
      end
   end

   // ss_n high wins over a coincident sclk edge: the frame is abandoned.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      case (state_q)
         ST_IDLE: begin
            if (!ss_s) begin
               state_d = ST_SHIFT;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            if (ss_s) begin
               state_d = ST_IDLE;
            end else if (sclk_rise) begin
               shift_d = {shift_q[F-2:0], mosi_s};
               cnt_d   = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(F - 1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ss_s ? ST_IDLE : ST_IGNORE;
         end
         ST_IGNORE: begin
            if (ss_s) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      wr_en       = (state_q == ST_DONE);
      wr_addr     = shift_q[F-1 -: ADDR_W];
      wr_data     = shift_q[REG_W-1:0];
      frame_err_d = (state_q == ST_SHIFT) && ss_s && (cnt_q != '0);
   end

   generate
      if (IMMEDIATE != 0) begin : g_imm
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int n = 0; n < NREG; n++) begin
                  live_q[n] <= '0;
               end
            end else if (wr_en) begin
               live_q[wr_addr] <= wr_data;
            end
         end

         assign o_pending = '0;
      end else begin : g_shd
         logic [REG_W-1:0] shadow_q [NREG];
         logic [NREG-1:0]  pending_q, pending_d;

         // A write landing on a commit cycle stays pending for the next commit.
         always_comb begin
            pending_d = i_commit ? '0 : pending_q;
            if (wr_en) begin
               pending_d[wr_addr] = 1'b1;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               for (int n = 0; n < NREG; n++) begin
                  live_q[n]   <= '0;
                  shadow_q[n] <= '0;
               end
               pending_q <= '0;
            end else begin
               for (int n = 0; n < NREG; n++) begin
                  if (i_commit && pending_q[n]) begin
                     live_q[n] <= shadow_q[n];
                  end
               end
               if (wr_en) begin
                  shadow_q[wr_addr] <= wr_data;
               end
               pending_q <= pending_d;
            end
         end

         assign o_pending = pending_q;
      end
   endgenerate

   for (genvar g = 0; g < NREG; g++) begin : g_out
      assign o_regs[g*REG_W +: REG_W] = live_q[g];
   end

   assign o_busy      = ~ss_s;
   assign o_frame_err = frame_err_q;

endmodule

// File: doc/rbz_spi_regs.md
# rbz_spi_regs

Parametrised SPI-slave register bank for the raybox-zero renderer: a successor to the top level's fixed three-pin SPI slave path. Synchronises the SPI pins into the system clock domain and decodes address+data frames. Writes land in shadow registers, which are committed to the live outputs on a frame-boundary strobe (typically vblank start), or written straight through in immediate mode. Reports per-register pending flags, bus activity and framing errors.

## Interface
- ADDR_W, 3: address bits per frame; bank holds 2**ADDR_W registers.
- REG_W, 16: data bits per register.
- SYNC_STAGES, 2: synchroniser flops on each SPI pin (min 2).
- IMMEDIATE, 0: 1 = completed writes go directly to live regs; shadows and pending are unused (pending stays 0).

- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_sclk  in  1  SPI clock, mode 0 (sample on rising edge), asynchronous.
- i_mosi  in  1  SPI data, MSB first, asynchronous.
- i_ss_n  in  1  SPI select, active-low, asynchronous.
- i_commit  in  1  single-cycle commit strobe (synchronous to clk).
- o_regs  out  (2**ADDR_W)*REG_W  live registers, reg n at [n*REG_W +: REG_W].
- o_pending  out  2**ADDR_W  bit n = shadow n written since last commit.
- o_busy  out  1  synchronised ss_n is active.
- o_frame_err  out  1  one-cycle pulse on a truncated frame.

## Operation
- Synchronisers reset to: sclk 0, mosi 0, ss_n 1. A registered copy of the synced sclk gives rising-edge detect (sclk_rise).
- Frame = ADDR_W address bits then REG_W data bits, MSB first; total F = ADDR_W+REG_W.
- FSM states: IDLE, SHIFT, DONE, IGNORE.
  - IDLE: when synced ss_n is low, clear bit counter and go to SHIFT.
  - SHIFT: on each sclk_rise, shift synced mosi into an F-bit shift register and increment the counter. When the count reaches F, go to DONE.
  - DONE: lasts one cycle. Write data to shadow[addr] (or live[addr] if IMMEDIATE), set pending[addr] (if not IMMEDIATE), then go to IGNORE.
  - IGNORE: further sclk_rise is discarded until synced ss_n goes high.
- Synced ss_n high in any state returns the FSM to IDLE next cycle.
  - If this happens in SHIFT with 0 < count < F: pulse o_frame_err for one cycle; no write.
  - If count == 0: no error.
- Multiple frames need separate ss_n assertions.
- Commit (IMMEDIATE=0): on a cycle with i_commit=1, every register n with pending[n]=1 copies shadow[n] to live[n]; all pending bits clear. Registers that are not pending are unchanged.
- Commit and DONE in the same cycle: the commit uses the pre-edge shadow/pending values. The new write lands in shadow, and its pending bit is set after the edge, so it is held for the next commit. If the write address was already pending, the old shadow value is committed.
- Rewriting a pending register before commit overwrites its shadow; last write wins.
- IMMEDIATE=1: i_commit is ignored.
- Reset values: o_regs all 0, shadows 0, o_pending 0, o_busy 0, o_frame_err 0, FSM IDLE. Reset mid-frame discards the partial frame with no error pulse.

## Timing
- An edge on a pin is visible in synced form SYNC_STAGES clk edges later. sclk_rise is asserted in the cycle the synced sclk first reads 1 against registered 0. The bit shifts in on the clk edge ending that cycle.
- Final bit shifted on edge E. The DONE write is visible on shadow/live/o_pending after edge E+1.
- Commit: o_regs and cleared o_pending are visible after the clk edge on which i_commit=1 is sampled (1-cycle latency).
- o_busy tracks synced ss_n inverted: it rises SYNC_STAGES cycles after i_ss_n falls.
- o_frame_err pulses in the cycle after synced ss_n is first seen high in SHIFT.
- SPI limits: sclk high and low each ≥ SYNC_STAGES+1 clk periods. ss_n setup to first sclk rise ≥ SYNC_STAGES+1 clk periods. ss_n high time between frames ≥ SYNC_STAGES+2 clk periods.

## Test plan
- Reset then idle: o_regs=0, o_pending=0, o_busy=0; i_commit pulses leave o_regs=0.
- Defaults, write addr 5 data 0xBEEF:
  - o_pending=0x20 two cycles after the last bit is synced in; o_regs unchanged.
  - After i_commit: reg5=0xBEEF, o_pending=0.
- Truncated frame (ss_n high after 10 bits):
  - o_frame_err pulses exactly once; shadows and o_pending unchanged.
  - A following full frame to addr 1 data 0x1234 commits correctly.
- Frame with 25 sclk pulses to addr 2 data 0x00FF: the extra 6 bits are ignored; reg2=0x00FF after commit; no o_frame_err.
- Write addr 3 = 0xAAAA and commit. Then write addr 3 = 0x5555 timed so DONE coincides with i_commit: reg3 stays 0xAAAA and o_pending=0x08. The next commit gives reg3=0x5555.
- IMMEDIATE=1, write addr 0 = 0x0F0F: reg0=0x0F0F at edge E+1 with no commit; o_pending stays 0. rst_n pulsed low mid-frame returns all outputs to 0 asynchronously.
